demod_dac_router: RTL and testbench

//  Parametrised successor to the fixed three-DAC demod output path. Routes any of NUM_SRC

---
 rtl/demod_dac_router.sv | 149 ++++++++++++++
 tb/tb_demod_dac_router.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_dac_router.sv
// Routes NUM_SRC demod sample streams to NUM_DAC DAC ports, each with its own source select,
// decimation, saturating gain shift and saturating offset, configured over the rd/wr0..wr3 bus.
module demod_dac_router #(
  parameter int          NUM_SRC   = 8,
  parameter int          NUM_DAC   = 3,
  parameter int          DAT_W     = 18,
  parameter logic [11:0] BASE_ADDR = 12'h100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     syncIn,
  input  logic                     rd,
  input  logic                     wr0,
  input  logic                     wr1,
  input  logic                     wr2,
  input  logic                     wr3,
  input  logic [11:0]              addr,
  input  logic [31:0]              din,
  output logic [31:0]              dout,
  input  logic [NUM_SRC*DAT_W-1:0] srcData,
  input  logic [NUM_SRC-1:0]       srcSync,
  output logic [NUM_DAC-1:0]       dacSync,
  output logic [NUM_DAC*DAT_W-1:0] dacData
);

  localparam int WW = DAT_W + 9;
  localparam logic signed [WW-1:0] SAT_MAX = {10'h000, {(DAT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {10'h3FF, {(DAT_W-1){1'b0}}};
  localparam logic [4:0] NSRC = 5'(NUM_SRC);

  function automatic logic [DAT_W-1:0] sat(input logic signed [WW-1:0] v);
    logic [DAT_W-1:0] r;
    if (v > SAT_MAX) r = SAT_MAX[DAT_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DAT_W-1:0];
    else r = v[DAT_W-1:0];
    return r;
  endfunction

  // Streams padded to 16 so any 4-bit srcSel indexes safely; unused slots read as idle.
  logic [DAT_W-1:0] src_arr [16];
  logic [15:0]      sync_ext;
  for (genvar s = 0; s < 16; s++) begin : g_src
    if (s < NUM_SRC) begin : g_live
      assign src_arr[s]  = srcData[s*DAT_W +: DAT_W];
      assign sync_ext[s] = srcSync[s];
    end else begin : g_pad
      assign src_arr[s]  = '0;
      assign sync_ext[s] = 1'b0;
    end
  end

  logic [9:0]  rel_s;
  logic        unused_addr_s;
  logic [31:0] lane_mask_s;
  assign rel_s         = addr[11:2] - BASE_ADDR[11:2];
  assign unused_addr_s = ^addr[1:0];
  assign lane_mask_s   = {{8{wr3}}, {8{wr2}}, {8{wr1}}, {8{wr0}}};

  logic [31:0]      cfg_q [NUM_DAC];
  logic [31:0]      cfg_d [NUM_DAC];
  logic [7:0]       cnt_q [NUM_DAC];
  logic [7:0]       cnt_d [NUM_DAC];
  logic [DAT_W-1:0] s1_q  [NUM_DAC];
  logic [DAT_W-1:0] s1_d  [NUM_DAC];
  logic [DAT_W-1:0] s2_q  [NUM_DAC];
  logic [DAT_W-1:0] s2_d  [NUM_DAC];
  logic [DAT_W-1:0] out_q [NUM_DAC];
  logic [DAT_W-1:0] out_d [NUM_DAC];
  logic [NUM_DAC-1:0] v1_q, v1_d, v2_q, v2_d, sync_q, sync_d;

  logic [3:0]         sel_s     [NUM_DAC];
  logic [7:0]         cnt_eff_s [NUM_DAC];
  logic [NUM_DAC-1:0] wr_hit_s, stb_s, emit_s;

  // syncIn zeroes the effective count this cycle, so a coincident strobe emits and reloads.
  always_comb begin
    v1_d   = '0;
    v2_d   = v1_q;
    sync_d = v2_q;
    for (int k = 0; k < NUM_DAC; k++) begin
      wr_hit_s[k]  = (rel_s == 10'(k));
      sel_s[k]     = cfg_q[k][3:0];
      stb_s[k]     = cfg_q[k][7] && ({1'b0, sel_s[k]} < NSRC) && sync_ext[sel_s[k]];
      cnt_eff_s[k] = syncIn ? 8'd0 : cnt_q[k];
      cfg_d[k]     = wr_hit_s[k] ? ((cfg_q[k] & ~lane_mask_s) | (din & lane_mask_s)) : cfg_q[k];

      emit_s[k] = 1'b0;
      if (stb_s[k] && (cnt_eff_s[k] == 8'd0)) begin
        emit_s[k] = 1'b1;
        cnt_d[k]  = cfg_q[k][15:8];
      end else if (stb_s[k]) begin
        cnt_d[k] = cnt_eff_s[k] - 8'd1;
      end else begin
        cnt_d[k] = cnt_eff_s[k];
      end
      if (wr_hit_s[k] && (wr0 || wr1)) cnt_d[k] = 8'd0;
      else cnt_d[k] = cnt_d[k];

      v1_d[k] = emit_s[k];
      s1_d[k] = emit_s[k] ? src_arr[sel_s[k]] : s1_q[k];
      s2_d[k] = v1_q[k] ? sat(WW'(signed'(s1_q[k])) <<< cfg_q[k][6:4]) : s2_q[k];
      out_d[k] = v2_q[k]
               ? sat(WW'(signed'(s2_q[k])) + (WW'(signed'(cfg_q[k][31:16])) <<< (DAT_W-16)))
               : out_q[k];
    end
  end

  // Read data is zero unless addressed, so several blocks can share an OR-merged bus.
  always_comb begin
    dout = 32'h0000_0000;
    for (int k = 0; k < NUM_DAC; k++) begin
      if (rd && (rel_s == 10'(k))) dout = cfg_q[k];
      else dout = dout;
    end
  end

  // Config, decimation counters and the three-stage sample pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_DAC; k++) begin
        cfg_q[k] <= 32'h0000_0000;
        cnt_q[k] <= 8'd0;
        s1_q[k]  <= '0;
        s2_q[k]  <= '0;
        out_q[k] <= '0;
      end
      v1_q   <= '0;
      v2_q   <= '0;
      sync_q <= '0;
    end else begin
      for (int k = 0; k < NUM_DAC; k++) begin
        cfg_q[k] <= cfg_d[k];
        cnt_q[k] <= cnt_d[k];
        s1_q[k]  <= s1_d[k];
        s2_q[k]  <= s2_d[k];
        out_q[k] <= out_d[k];
      end
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      sync_q <= sync_d;
    end
  end

  assign dacSync = sync_q;
  for (genvar k = 0; k < NUM_DAC; k++) begin : g_out
    assign dacData[k*DAT_W +: DAT_W] = out_q[k];
  end

endmodule

// File: tb/tb_demod_dac_router.sv
// Randomized self-checking bench for demod_dac_router against a cycle-scheduled behavioural model.
module tb_demod_dac_router;
  localparam int NUM_SRC = 8;
  localparam int NUM_DAC = 3;
  localparam int DAT_W   = 18;
  localparam logic [11:0] BASE = 12'h100;

  logic clk, reset, syncIn, rd, wr0, wr1, wr2, wr3;
  logic [11:0] addr;
  logic [31:0] din, dout;
  logic [NUM_SRC*DAT_W-1:0] srcData;
  logic [NUM_SRC-1:0] srcSync;
  logic [NUM_DAC-1:0] dacSync;
  logic [NUM_DAC*DAT_W-1:0] dacData;

  demod_dac_router dut (
    .clk(clk), .reset(reset), .syncIn(syncIn), .rd(rd),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .addr(addr), .din(din), .dout(dout),
    .srcData(srcData), .srcSync(srcSync),
    .dacSync(dacSync), .dacData(dacData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: config, decimation counts, and a table of outputs scheduled by cycle number.
  logic [31:0]      m_cfg  [NUM_DAC];
  int               m_cnt  [NUM_DAC];
  bit               m_pv   [NUM_DAC][4];
  logic [DAT_W-1:0] m_pd   [NUM_DAC][4];
  logic [DAT_W-1:0] m_last [NUM_DAC];
  bit               e_sync [NUM_DAC];
  int               cyc;

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (DAT_W-1)) - 1;
    lo = -(longint'(1) << (DAT_W-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [DAT_W-1:0] m_out(input logic [31:0] cfg, input logic [DAT_W-1:0] x);
    longint v;
    v = clamp(longint'($signed(x)) * (longint'(1) << cfg[6:4]));
    v = clamp(v + longint'($signed(cfg[31:16])) * (longint'(1) << (DAT_W-16)));
    return DAT_W'(v);
  endfunction

  task automatic m_clear();
    for (int k = 0; k < NUM_DAC; k++) begin
      m_cfg[k] = 32'h0; m_cnt[k] = 0; m_last[k] = '0; e_sync[k] = 1'b0;
      for (int j = 0; j < 4; j++) begin m_pv[k][j] = 1'b0; m_pd[k][j] = '0; end
    end
  endtask

  task automatic set_idle();
    srcSync = '0; syncIn = 1'b0; rd = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
  endtask

  // Advance one clock: evaluate the model on the current inputs, then clock and settle.
  task automatic step();
    bit em [NUM_DAC];
    logic [DAT_W-1:0] ev [NUM_DAC];
    logic [15:0] ss;
    logic [3:0] sel;
    int idx, c;
    ss  = 16'(srcSync);
    idx = int'(addr >> 2) - int'(BASE >> 2);
    for (int k = 0; k < NUM_DAC; k++) begin
      sel = m_cfg[k][3:0];
      c = syncIn ? 0 : m_cnt[k];
      em[k] = 1'b0; ev[k] = '0;
      if (m_cfg[k][7] && int'(sel) < NUM_SRC && ss[sel]) begin
        if (c == 0) begin
          em[k] = 1'b1;
          ev[k] = m_out(m_cfg[k], srcData[sel*DAT_W +: DAT_W]);
          c = int'(m_cfg[k][15:8]);
        end else c = c - 1;
      end
      m_cnt[k] = c;
      if (idx == k) begin
        if (wr0) m_cfg[k][7:0]   = din[7:0];
        if (wr1) m_cfg[k][15:8]  = din[15:8];
        if (wr2) m_cfg[k][23:16] = din[23:16];
        if (wr3) m_cfg[k][31:24] = din[31:24];
        if (wr0 || wr1) m_cnt[k] = 0;
      end
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NUM_DAC; k++) begin
      if (em[k]) begin m_pv[k][(cyc+2)%4] = 1'b1; m_pd[k][(cyc+2)%4] = ev[k]; end
      e_sync[k] = m_pv[k][cyc%4];
      if (e_sync[k]) m_last[k] = m_pd[k][cyc%4];
      m_pv[k][cyc%4] = 1'b0;
    end
    #1;
  endtask

  task automatic wr_reg(input int k, input logic [31:0] val, input logic [3:0] lanes);
    addr = BASE + 12'(4*k); din = val;
    wr0 = lanes[0]; wr1 = lanes[1]; wr2 = lanes[2]; wr3 = lanes[3];
    step();
    wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
  endtask

  task automatic test_reset();
    rd = 1'b1; addr = BASE; #1;
    checks++;
    if (dacSync !== '0 || dacData !== '0 || dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: got sync=%b data=%h dout=%h, want all zero", dacSync, dacData, dout);
    end
    reset = 1'b1; m_clear(); cyc = 0;
    for (int k = 0; k < NUM_DAC; k++) begin
      addr = BASE + 12'(4*k); #1;
      checks++;
      if (dout !== 32'h0) begin
        failures++; $display("FAIL reset_regs reg%0d: got %h want 00000000", k, dout);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_route();
    wr_reg(1, 32'h0000_0082, 4'hF);
    srcData[2*DAT_W +: DAT_W] = 18'h00123; srcSync = 8'b0000_0100;
    step(); srcSync = '0; step(); step();
    checks++;
    if (dacSync[1] !== 1'b1 || dacData[DAT_W +: DAT_W] !== 18'h00123) begin
      failures++;
      $display("FAIL route: got sync=%b data=%h, want sync=1 data=00123", dacSync[1], dacData[DAT_W +: DAT_W]);
    end
    step();
    checks++;
    if (dacSync[1] !== 1'b0 || dacData[DAT_W +: DAT_W] !== 18'h00123) begin
      failures++;
      $display("FAIL route_hold: got sync=%b data=%h, want sync=0 data=00123", dacSync[1], dacData[DAT_W +: DAT_W]);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] cfgs [2];
    logic [DAT_W-1:0] ins [2], outs [2];
    cfgs[0] = 32'h0000_00A0; ins[0] = 18'h10000; outs[0] = 18'h1FFFF;
    cfgs[1] = 32'h8000_0080; ins[1] = 18'h20000; outs[1] = 18'h20000;
    for (int i = 0; i < 2; i++) begin
      wr_reg(0, cfgs[i], 4'hF);
      srcData[0 +: DAT_W] = ins[i]; srcSync = 8'b0000_0001;
      step(); srcSync = '0; step(); step();
      checks++;
      if (dacSync[0] !== 1'b1 || dacData[0 +: DAT_W] !== outs[i]) begin
        failures++;
        $display("FAIL saturate%0d: got sync=%b data=%h, want sync=1 data=%h", i, dacSync[0], dacData[0 +: DAT_W], outs[i]);
      end
    end
  endtask

  task automatic test_decim(input bit use_sync);
    logic [11:0] mask, want;
    mask = '0;
    want = use_sync ? 12'h445 : 12'h111;
    wr_reg(2, 32'h0000_0383, 4'hF);
    for (int t = 0; t < 26; t++) begin
      if (t < 24 && t % 2 == 0) begin
        srcSync = 8'b0000_1000; srcData[3*DAT_W +: DAT_W] = DAT_W'($urandom);
        syncIn = use_sync && (t == 4);
      end else begin
        srcSync = '0; syncIn = 1'b0;
      end
      step();
      if (dacSync[2] === 1'b1 && t >= 2) mask[(t-2)/2] = 1'b1;
      for (int k = 0; k < NUM_DAC; k++) begin
        checks++;
        if (dacSync[k] !== e_sync[k] || dacData[k*DAT_W +: DAT_W] !== m_last[k]) begin
          failures++;
          $display("FAIL decim_model dac%0d t=%0d: got sync=%b data=%h, want sync=%b data=%h", k, t, dacSync[k], dacData[k*DAT_W +: DAT_W], e_sync[k], m_last[k]);
        end
      end
    end
    checks++;
    if (mask !== want) begin
      failures++; $display("FAIL decim_pattern sync=%0d: got strobes %b want %b", use_sync, mask, want);
    end
  endtask

  task automatic test_bus();
    wr_reg(0, 32'h0, 4'hF);
    wr_reg(0, 32'h00AB_0000, 4'b0100);
    rd = 1'b1; addr = BASE; #1;
    checks++;
    if (dout !== 32'h00AB_0000) begin failures++; $display("FAIL bus_lane2: got %h want 00ab0000", dout); end
    addr = BASE + 12'd2; #1;
    checks++;
    if (dout !== 32'h00AB_0000) begin failures++; $display("FAIL bus_lowbits: got %h want 00ab0000", dout); end
    addr = BASE + 12'(4*NUM_DAC); #1;
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL bus_unmapped_hi: got %h want 0", dout); end
    addr = BASE - 12'd4; #1;
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL bus_unmapped_lo: got %h want 0", dout); end
    rd = 1'b0; addr = BASE + 12'd8; #1;
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL bus_nord: got %h want 0", dout); end
    rd = 1'b1; #1;
    checks++;
    if (dout !== m_cfg[2]) begin failures++; $display("FAIL bus_reg2: got %h want %h", dout, m_cfg[2]); end
    rd = 1'b0;
    wr_reg(1, 32'h0000_008F, 4'hF);
    for (int t = 0; t < 6; t++) begin
      srcSync = (t < 4) ? '1 : '0;
      step();
      checks++;
      if (dacSync[1] !== 1'b0) begin failures++; $display("FAIL bus_badsel t=%0d: got sync=%b want 0", t, dacSync[1]); end
    end
  endtask

  task automatic test_enable_clear();
    int pulses;
    pulses = 0;
    wr_reg(1, 32'h0000_0082, 4'hF);
    for (int t = 0; t < 8; t++) begin
      srcSync = (t < 4) ? 8'b0000_0100 : '0;
      srcData[2*DAT_W +: DAT_W] = DAT_W'($urandom);
      if (t == 1) begin addr = BASE + 12'd4; din = 32'h0000_0002; wr0 = 1'b1; end
      step();
      wr0 = 1'b0;
      if (dacSync[1] === 1'b1) pulses++;
      for (int k = 0; k < NUM_DAC; k++) begin
        checks++;
        if (dacSync[k] !== e_sync[k] || dacData[k*DAT_W +: DAT_W] !== m_last[k]) begin
          failures++;
          $display("FAIL enable_model dac%0d t=%0d: got sync=%b data=%h, want sync=%b data=%h", k, t, dacSync[k], dacData[k*DAT_W +: DAT_W], e_sync[k], m_last[k]);
        end
      end
    end
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL enable_clear: got %0d pulses want 2", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cfg;
    logic [DAT_W-1:0] d [4];
    logic [DAT_W-1:0] got [$];
    int first;
    first = -1;
    cfg = {16'($urandom_range(0, 16'h0FFF)), 16'h0095};
    wr_reg(0, cfg, 4'hF);
    for (int t = 0; t < 8; t++) begin
      if (t < 4) begin
        d[t] = DAT_W'($urandom);
        srcData[5*DAT_W +: DAT_W] = d[t]; srcSync = 8'b0010_0000;
      end else srcSync = '0;
      step();
      if (dacSync[0] === 1'b1) begin
        if (first < 0) first = t;
        if (t - first == got.size()) got.push_back(dacData[0 +: DAT_W]);
      end
    end
    checks++;
    if (got.size() != 4 || first != 2) begin
      failures++; $display("FAIL b2b_count: got %0d consecutive pulses from step %0d, want 4 from step 2", got.size(), first);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== m_out(cfg, d[i])) begin
        failures++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], m_out(cfg, d[i]));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < NUM_DAC; k++)
      wr_reg(k, {16'($urandom), 8'($urandom_range(0, 3)), 1'b1, 3'($urandom), 4'($urandom_range(0, 9))}, 4'hF);
    for (int t = 0; t < 150; t++) begin
      srcSync = NUM_SRC'($urandom);
      for (int s = 0; s < NUM_SRC; s++) srcData[s*DAT_W +: DAT_W] = DAT_W'($urandom);
      syncIn = ($urandom_range(0, 15) == 0);
      step();
      for (int k = 0; k < NUM_DAC; k++) begin
        checks++;
        if (dacSync[k] !== e_sync[k] || dacData[k*DAT_W +: DAT_W] !== m_last[k]) begin
          failures++;
          $display("FAIL random_model dac%0d t=%0d: got sync=%b data=%h, want sync=%b data=%h", k, t, dacSync[k], dacData[k*DAT_W +: DAT_W], e_sync[k], m_last[k]);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    srcSync = '1;
    repeat (3) step();
    #2 reset = 1'b0; #1;
    m_clear();
    checks++;
    if (dacSync !== '0 || dacData !== '0) begin
      failures++; $display("FAIL reset_mid: got sync=%b data=%h, want zero", dacSync, dacData);
    end
    step(); step();
    reset = 1'b1;
    rd = 1'b1;
    for (int k = 0; k < NUM_DAC; k++) begin
      addr = BASE + 12'(4*k); #1;
      checks++;
      if (dout !== 32'h0) begin failures++; $display("FAIL reset_mid_reg%0d: got %h want 0", k, dout); end
    end
    rd = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step();
      checks++;
      if (dacSync !== '0 || dacData !== '0) begin
        failures++; $display("FAIL reset_mid_after t=%0d: got sync=%b data=%h, want zero", t, dacSync, dacData);
      end
    end
    set_idle();
  endtask

  initial begin
    reset = 1'b0; set_idle(); addr = BASE; din = 32'h0; srcData = '0;
    m_clear(); cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_route();
    test_saturate();
    test_decim(1'b0);
    test_decim(1'b1);
    test_bus();
    test_enable_clear();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
